// File: rtl/id_stage_pipe_pkg.sv
// id_stage_pipe_pkg: shared widths, MIPS opcode/func constants, ALU-op and operand-select bit
// positions, the decoded control word layout and the branch-kind enum used by the decode stage.
package id_stage_pipe_pkg;

  // Producer bus layout: {we[38], is_load[37], waddr[36:32], wdata[31:0]}
  localparam int unsigned FWD_WD        = 39;
  localparam int unsigned FWD_WE_BIT    = 38;
  localparam int unsigned FWD_LOAD_BIT  = 37;
  localparam int unsigned FWD_WADDR_LSB = 32;

  localparam int unsigned ID_TO_EX_WD = 159;
  localparam int unsigned BR_WD       = 33;

  // Primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // SPECIAL func codes
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;

  // alu_op one-hot bit positions
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLT  = 2;
  localparam int unsigned ALU_SLTU = 3;
  localparam int unsigned ALU_AND  = 4;
  localparam int unsigned ALU_NOR  = 5;
  localparam int unsigned ALU_OR   = 6;
  localparam int unsigned ALU_XOR  = 7;
  localparam int unsigned ALU_SLL  = 8;
  localparam int unsigned ALU_SRL  = 9;
  localparam int unsigned ALU_SRA  = 10;
  localparam int unsigned ALU_LUI  = 11;

  // src1 select bits
  localparam int unsigned SRC1_RS = 0;
  localparam int unsigned SRC1_PC = 1;
  localparam int unsigned SRC1_SA = 2;

  // src2 select bits
  localparam int unsigned SRC2_RT   = 0;
  localparam int unsigned SRC2_SIMM = 1;
  localparam int unsigned SRC2_ZIMM = 2;
  localparam int unsigned SRC2_8    = 3;

  // Decoded control fields, in id_to_ex_bus order between inst and rdata1
  typedef struct packed {
    logic [11:0] alu_op;
    logic [2:0]  src1;
    logic [3:0]  src2;
    logic        ram_en;
    logic [3:0]  ram_wen;
    logic        rf_we;
    logic [4:0]  waddr;
    logic        sel_rf_res;
  } ctrl_t;

  typedef enum logic [2:0] {
    BrNone,
    BrBeq,
    BrBne,
    BrJ,
    BrJr
  } br_kind_e;

  // Sign-extended word offset of a conditional branch
  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// id_fwd_mux: operand select for one register read port. $0 reads as zero, otherwise the
// youngest producer (lowest bus index) writing the register wins, otherwise the regfile value.
module id_fwd_mux
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3
) (
  input  logic [4:0]                addr,
  input  logic [31:0]               rf_rdata,
  input  logic [NUM_FWD*FWD_WD-1:0] fwd_bus,
  output logic [31:0]               data
);

  logic w_unused_load;

  // Walk oldest to youngest so the lowest matching index overrides the rest.
  always_comb begin
    data = rf_rdata;
    for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
      if (fwd_bus[i*FWD_WD + FWD_WE_BIT] &&
          (fwd_bus[i*FWD_WD + FWD_WADDR_LSB +: 5] == addr)) begin
        data = fwd_bus[i*FWD_WD +: 32];
      end
    end
    if (addr == 5'd0) begin
      data = '0;
    end
  end

  // is_load only matters to the interlock in the parent; fold it away here.
  always_comb begin
    w_unused_load = 1'b0;
    for (int i = 0; i < int'(NUM_FWD); i++) begin
      w_unused_load = w_unused_load ^ fwd_bus[i*FWD_WD + FWD_LOAD_BIT];
    end
  end

endmodule

// File: rtl/id_stage_pipe.sv
// id_stage_pipe: MIPS decode stage between IF and EX with a valid/ready handshake, operand
// forwarding from NUM_FWD producer buses, a load-use interlock against the EX stage, and a
// held-instruction buffer so the SRAM word survives stalls. Branches and jumps resolve here;
// the delay slot always executes so nothing is squashed on a taken branch.
// Optional feature macro ID_PERF_CNT_EN adds saturating stall_cnt / br_cnt outputs.
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int unsigned NUM_FWD = 3
`ifdef ID_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W = 32
`endif
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_pc,
  input  logic [31:0]               inst_sram_rdata,
  output logic [4:0]                rf_raddr1,
  output logic [4:0]                rf_raddr2,
  input  logic [31:0]               rf_rdata1,
  input  logic [31:0]               rf_rdata2,
  input  logic [NUM_FWD*FWD_WD-1:0] fwd_bus,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_TO_EX_WD-1:0]    id_to_ex_bus,
  output logic [BR_WD-1:0]          br_bus,
  output logic                      stallreq
`ifdef ID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          br_cnt
`endif
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst_buf;
  logic        r_inst_buf_v;

  logic [31:0] w_inst;
  logic [5:0]  w_opcode;
  logic [5:0]  w_func;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [25:0] w_idx;

  ctrl_t       w_ctrl;
  br_kind_e    w_br_kind;
  logic        w_uses_rs;
  logic        w_uses_rt;

  logic [31:0] w_rdata1;
  logic [31:0] w_rdata2;

  logic        w_ex_we;
  logic        w_ex_load;
  logic [4:0]  w_ex_waddr;
  logic        w_load_use;
  logic        w_out_valid;
  logic        w_advance;
  logic        w_accept;

  logic        w_taken;
  logic        w_br_e;
  logic [31:0] w_pc4;
  logic [31:0] w_br_addr;

  // Once stalled the SRAM has moved on, so the captured copy takes over.
  assign w_inst   = r_inst_buf_v ? r_inst_buf : inst_sram_rdata;
  assign w_opcode = w_inst[31:26];
  assign w_rs     = w_inst[25:21];
  assign w_rt     = w_inst[20:16];
  assign w_rd     = w_inst[15:11];
  assign w_func   = w_inst[5:0];
  assign w_imm    = w_inst[15:0];
  assign w_idx    = w_inst[25:0];

  assign rf_raddr1 = w_rs;
  assign rf_raddr2 = w_rt;

  // Instruction decode; unsupported encodings fall through as a NOP.
  always_comb begin
    w_ctrl    = '0;
    w_br_kind = BrNone;
    w_uses_rs = 1'b0;
    w_uses_rt = 1'b0;
    case (w_opcode)
      OP_SPECIAL: begin
        case (w_func)
          FN_ADDU, FN_SUBU: begin
            w_ctrl.alu_op[ALU_ADD] = (w_func == FN_ADDU);
            w_ctrl.alu_op[ALU_SUB] = (w_func == FN_SUBU);
            w_ctrl.src1[SRC1_RS]   = 1'b1;
            w_ctrl.src2[SRC2_RT]   = 1'b1;
            w_ctrl.rf_we           = 1'b1;
            w_ctrl.waddr           = w_rd;
            w_uses_rs              = 1'b1;
            w_uses_rt              = 1'b1;
          end
          FN_JR: begin
            w_br_kind = BrJr;
            w_uses_rs = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J: begin
        w_br_kind = BrJ;
      end
      OP_JAL: begin
        // Link value pc+8 is formed in EX as pc + 8.
        w_br_kind              = BrJ;
        w_ctrl.alu_op[ALU_ADD] = 1'b1;
        w_ctrl.src1[SRC1_PC]   = 1'b1;
        w_ctrl.src2[SRC2_8]    = 1'b1;
        w_ctrl.rf_we           = 1'b1;
        w_ctrl.waddr           = 5'd31;
      end
      OP_BEQ, OP_BNE: begin
        w_br_kind = (w_opcode == OP_BEQ) ? BrBeq : BrBne;
        w_uses_rs = 1'b1;
        w_uses_rt = 1'b1;
      end
      OP_ADDIU: begin
        w_ctrl.alu_op[ALU_ADD] = 1'b1;
        w_ctrl.src1[SRC1_RS]   = 1'b1;
        w_ctrl.src2[SRC2_SIMM] = 1'b1;
        w_ctrl.rf_we           = 1'b1;
        w_ctrl.waddr           = w_rt;
        w_uses_rs              = 1'b1;
      end
      OP_ORI: begin
        w_ctrl.alu_op[ALU_OR]  = 1'b1;
        w_ctrl.src1[SRC1_RS]   = 1'b1;
        w_ctrl.src2[SRC2_ZIMM] = 1'b1;
        w_ctrl.rf_we           = 1'b1;
        w_ctrl.waddr           = w_rt;
        w_uses_rs              = 1'b1;
      end
      OP_LUI: begin
        w_ctrl.alu_op[ALU_LUI] = 1'b1;
        w_ctrl.src2[SRC2_ZIMM] = 1'b1;
        w_ctrl.rf_we           = 1'b1;
        w_ctrl.waddr           = w_rt;
      end
      OP_LW: begin
        w_ctrl.alu_op[ALU_ADD] = 1'b1;
        w_ctrl.src1[SRC1_RS]   = 1'b1;
        w_ctrl.src2[SRC2_SIMM] = 1'b1;
        w_ctrl.ram_en          = 1'b1;
        w_ctrl.rf_we           = 1'b1;
        w_ctrl.waddr           = w_rt;
        w_ctrl.sel_rf_res      = 1'b1;
        w_uses_rs              = 1'b1;
      end
      OP_SW: begin
        w_ctrl.alu_op[ALU_ADD] = 1'b1;
        w_ctrl.src1[SRC1_RS]   = 1'b1;
        w_ctrl.src2[SRC2_SIMM] = 1'b1;
        w_ctrl.ram_en          = 1'b1;
        w_ctrl.ram_wen         = 4'hf;
        w_uses_rs              = 1'b1;
        w_uses_rt              = 1'b1;
      end
      default: ;
    endcase
  end

  id_fwd_mux #(
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rs (
    .addr     (w_rs),
    .rf_rdata (rf_rdata1),
    .fwd_bus  (fwd_bus),
    .data     (w_rdata1)
  );

  id_fwd_mux #(
    .NUM_FWD (NUM_FWD)
  ) u_fwd_rt (
    .addr     (w_rt),
    .rf_rdata (rf_rdata2),
    .fwd_bus  (fwd_bus),
    .data     (w_rdata2)
  );

  // A load still in EX has no data yet; hold until it moves to MEM.
  assign w_ex_we    = fwd_bus[FWD_WE_BIT];
  assign w_ex_load  = fwd_bus[FWD_LOAD_BIT];
  assign w_ex_waddr = fwd_bus[FWD_WADDR_LSB +: 5];
  assign w_load_use = r_valid & w_ex_we & w_ex_load & (w_ex_waddr != 5'd0) &
                      ((w_uses_rs & (w_ex_waddr == w_rs)) | (w_uses_rt & (w_ex_waddr == w_rt)));

  assign w_out_valid = r_valid & ~w_load_use & ~flush;
  assign w_advance   = w_out_valid & out_ready;
  assign in_ready    = ~r_valid | w_advance;
  assign w_accept    = in_valid & in_ready & ~flush;

  assign out_valid = w_out_valid;
  assign stallreq  = w_load_use & ~flush;

  assign w_pc4 = r_pc + 32'd4;

  // Branch condition and target from forwarded operands.
  always_comb begin
    w_taken   = 1'b0;
    w_br_addr = '0;
    case (w_br_kind)
      BrBeq: begin
        w_taken   = (w_rdata1 == w_rdata2);
        w_br_addr = w_pc4 + br_offset(w_imm);
      end
      BrBne: begin
        w_taken   = (w_rdata1 != w_rdata2);
        w_br_addr = w_pc4 + br_offset(w_imm);
      end
      BrJ: begin
        w_taken   = 1'b1;
        w_br_addr = {w_pc4[31:28], w_idx, 2'b00};
      end
      BrJr: begin
        w_taken   = 1'b1;
        w_br_addr = w_rdata1;
      end
      default: ;
    endcase
  end

  // Redirect only in the cycle the branch leaves ID so IF never sees it twice.
  assign w_br_e = w_advance & w_taken;
  assign br_bus = w_br_e ? {1'b1, w_br_addr} : '0;

  assign id_to_ex_bus = flush ? '0 : {r_pc, w_inst, w_ctrl, w_rdata1, w_rdata2};

  // Stage occupancy and PC: flush empties, accept refills, advance without refill drains.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
    end else begin
      if (flush) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        r_valid <= 1'b1;
      end else if (w_advance) begin
        r_valid <= 1'b0;
      end
      if (w_accept) begin
        r_pc <= in_pc;
      end
    end
  end

  // Capture the SRAM word on the first held cycle; release on advance or flush.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_inst_buf   <= '0;
      r_inst_buf_v <= 1'b0;
    end else if (flush || w_advance) begin
      r_inst_buf_v <= 1'b0;
    end else if (r_valid && !r_inst_buf_v) begin
      r_inst_buf   <= inst_sram_rdata;
      r_inst_buf_v <= 1'b1;
    end
  end

`ifdef ID_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_br_cnt;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
      r_br_cnt    <= '0;
    end else begin
      if (stallreq && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (w_br_e && (r_br_cnt != '1)) begin
        r_br_cnt <= r_br_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign br_cnt    = r_br_cnt;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe: directed-vector bench for id_stage_pipe. Each task drives one scenario and
// compares outputs against hand-computed values. Counter checks build with ID_PERF_CNT_EN.
module tb_id_stage_pipe;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_pc;
  logic [31:0]  inst_sram_rdata;
  logic [4:0]   rf_raddr1;
  logic [4:0]   rf_raddr2;
  logic [31:0]  rf_rdata1;
  logic [31:0]  rf_rdata2;
  logic [116:0] fwd_bus;
  logic         out_valid;
  logic         out_ready;
  logic [158:0] id_to_ex_bus;
  logic [32:0]  br_bus;
  logic         stallreq;
`ifdef ID_PERF_CNT_EN
  logic [31:0]  stall_cnt;
  logic [31:0]  br_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  // id_to_ex_bus fields
  logic [31:0] f_pc, f_inst, f_rdata1, f_rdata2;
  logic [11:0] f_alu_op;
  logic [2:0]  f_src1;
  logic [3:0]  f_src2, f_ram_wen;
  logic        f_ram_en, f_rf_we, f_sel;
  logic [4:0]  f_waddr;
  assign f_pc      = id_to_ex_bus[158:127];
  assign f_inst    = id_to_ex_bus[126:95];
  assign f_alu_op  = id_to_ex_bus[94:83];
  assign f_src1    = id_to_ex_bus[82:80];
  assign f_src2    = id_to_ex_bus[79:76];
  assign f_ram_en  = id_to_ex_bus[75];
  assign f_ram_wen = id_to_ex_bus[74:71];
  assign f_rf_we   = id_to_ex_bus[70];
  assign f_waddr   = id_to_ex_bus[69:65];
  assign f_sel     = id_to_ex_bus[64];
  assign f_rdata1  = id_to_ex_bus[63:32];
  assign f_rdata2  = id_to_ex_bus[31:0];

  id_stage_pipe u_dut (
    .clk             (clk),
    .resetn          (resetn),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_pc           (in_pc),
    .inst_sram_rdata (inst_sram_rdata),
    .rf_raddr1       (rf_raddr1),
    .rf_raddr2       (rf_raddr2),
    .rf_rdata1       (rf_rdata1),
    .rf_rdata2       (rf_rdata2),
    .fwd_bus         (fwd_bus),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .id_to_ex_bus    (id_to_ex_bus),
    .br_bus          (br_bus),
    .stallreq        (stallreq)
`ifdef ID_PERF_CNT_EN
    ,
    .stall_cnt       (stall_cnt),
    .br_cnt          (br_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [38:0] mk_fwd(input logic we, input logic ld, input logic [4:0] wa,
                                         input logic [31:0] wd);
    return {we, ld, wa, wd};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush           = 1'b0;
    in_valid        = 1'b0;
    in_pc           = 32'h0;
    inst_sram_rdata = 32'h0;
    rf_rdata1       = 32'h1111_1111;
    rf_rdata2       = 32'h2222_2222;
    fwd_bus         = '0;
    out_ready       = 1'b1;
  endtask

  task automatic accept(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    idle();
    tick();
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL rst_stallreq: got %0b want 0", stallreq); end
    n_vec++; if (br_bus !== 33'h0) begin n_err++; $display("FAIL rst_br_bus: got %h want 0", br_bus); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_addiu();
    accept(32'h0000_0000);
    inst_sram_rdata = enc_i(6'h09, 5'd0, 5'd1, 16'd5);
    #2;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL addiu_valid: got %0b want 1", out_valid); end
    n_vec++; if (f_rf_we !== 1'b1) begin n_err++; $display("FAIL addiu_rf_we: got %0b want 1", f_rf_we); end
    n_vec++; if (f_waddr !== 5'd1) begin n_err++; $display("FAIL addiu_waddr: got %0d want 1", f_waddr); end
    n_vec++; if (f_alu_op !== 12'h001) begin n_err++; $display("FAIL addiu_alu_op: got %h want 001", f_alu_op); end
    n_vec++; if (f_rdata1 !== 32'h0) begin n_err++; $display("FAIL addiu_rdata1: got %h want 0", f_rdata1); end
    n_vec++; if (f_src2 !== 4'b0010) begin n_err++; $display("FAIL addiu_src2: got %b want 0010", f_src2); end
    n_vec++; if (rf_raddr2 !== 5'd1) begin n_err++; $display("FAIL addiu_raddr2: got %0d want 1", rf_raddr2); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL addiu_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_fwd();
    accept(32'h0000_0004);
    inst_sram_rdata = enc_r(5'd2, 5'd2, 5'd3, 6'h23);
    fwd_bus = {mk_fwd(1'b1, 1'b0, 5'd2, 32'h0000_BEEF), mk_fwd(1'b1, 1'b0, 5'd2, 32'h0000_DEAD),
               mk_fwd(1'b1, 1'b0, 5'd2, 32'h0000_1234)};
    #2;
    n_vec++; if (f_rdata1 !== 32'h1234) begin n_err++; $display("FAIL fwd_ex_rs: got %h want 1234", f_rdata1); end
    n_vec++; if (f_rdata2 !== 32'h1234) begin n_err++; $display("FAIL fwd_ex_rt: got %h want 1234", f_rdata2); end
    n_vec++; if (f_alu_op !== 12'h002) begin n_err++; $display("FAIL subu_alu_op: got %h want 002", f_alu_op); end
    fwd_bus[38] = 1'b0;
    #1;
    n_vec++; if (f_rdata1 !== 32'hDEAD) begin n_err++; $display("FAIL fwd_mem_rs: got %h want dead", f_rdata1); end
    fwd_bus[77] = 1'b0;
    #1;
    n_vec++; if (f_rdata2 !== 32'hBEEF) begin n_err++; $display("FAIL fwd_wb_rt: got %h want beef", f_rdata2); end
    fwd_bus[116] = 1'b0;
    #1;
    n_vec++; if (f_rdata1 !== 32'h1111_1111) begin n_err++; $display("FAIL fwd_rf_rs: got %h want 11111111", f_rdata1); end
    tick();
    idle();
  endtask

  task automatic test_load_use();
    accept(32'h0000_0008);
    inst_sram_rdata = enc_r(5'd4, 5'd0, 5'd5, 6'h21);
    fwd_bus  = {78'h0, mk_fwd(1'b1, 1'b1, 5'd4, 32'h0BAD_0BAD)};
    in_valid = 1'b1;
    in_pc    = 32'h0000_000C;
    #2;
    n_vec++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL lu_stallreq: got %0b want 1", stallreq); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_out_valid: got %0b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_in_ready: got %0b want 0", in_ready); end
    tick();
    in_valid        = 1'b0;
    inst_sram_rdata = 32'hFFFF_FFFF;
    fwd_bus         = {39'h0, mk_fwd(1'b1, 1'b0, 5'd4, 32'h77), 39'h0};
    #2;
    n_vec++; if (stallreq !== 1'b0) begin n_err++; $display("FAIL lu_release: got %0b want 0", stallreq); end
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL lu_resume: got %0b want 1", out_valid); end
    n_vec++; if (f_inst !== 32'h0080_2821) begin n_err++; $display("FAIL lu_held_inst: got %h want 00802821", f_inst); end
    n_vec++; if (f_rdata1 !== 32'h77) begin n_err++; $display("FAIL lu_rdata1: got %h want 77", f_rdata1); end
    n_vec++; if (f_pc !== 32'h8) begin n_err++; $display("FAIL lu_pc: got %h want 8", f_pc); end
    tick();
    idle();
  endtask

  task automatic test_branch();
    accept(32'h0000_0100);
    inst_sram_rdata = enc_i(6'h04, 5'd0, 5'd0, 16'd4);
    out_ready = 1'b0;
    #2;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid: got %0b want 1", out_valid); end
    n_vec++; if (br_bus !== 33'h0) begin n_err++; $display("FAIL beq_hold: got %h want 0", br_bus); end
    tick();
    inst_sram_rdata = 32'hFFFF_FFFF;
    out_ready = 1'b1;
    #2;
    n_vec++; if (br_bus !== {1'b1, 32'h0000_0114}) begin n_err++; $display("FAIL beq_taken: got %h want 1_00000114", br_bus); end
    tick();
    n_vec++; if (br_bus !== 33'h0) begin n_err++; $display("FAIL beq_once: got %h want 0", br_bus); end
    accept(32'h0000_0140);
    inst_sram_rdata = enc_i(6'h05, 5'd0, 5'd0, 16'd4);
    #2;
    n_vec++; if (br_bus !== 33'h0) begin n_err++; $display("FAIL bne_not_taken: got %h want 0", br_bus); end
    tick();
    idle();
  endtask

  task automatic test_jal();
    accept(32'hBFC0_0000);
    inst_sram_rdata = {6'h03, 26'h10};
    #2;
    n_vec++; if (br_bus !== {1'b1, 32'hB000_0040}) begin n_err++; $display("FAIL jal_target: got %h want 1_b0000040", br_bus); end
    n_vec++; if (f_waddr !== 5'd31) begin n_err++; $display("FAIL jal_waddr: got %0d want 31", f_waddr); end
    n_vec++; if (f_src1 !== 3'b010) begin n_err++; $display("FAIL jal_src1: got %b want 010", f_src1); end
    n_vec++; if (f_src2 !== 4'b1000) begin n_err++; $display("FAIL jal_src2: got %b want 1000", f_src2); end
    n_vec++; if (f_rf_we !== 1'b1) begin n_err++; $display("FAIL jal_rf_we: got %0b want 1", f_rf_we); end
    tick();
    idle();
  endtask

  task automatic test_decode_misc();
    accept(32'h0000_0180);
    inst_sram_rdata = 32'hFC22_0001;
    #2;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL nop_valid: got %0b want 1", out_valid); end
    n_vec++; if ({f_rf_we, f_ram_en} !== 2'b00) begin n_err++; $display("FAIL nop_ctrl: got %b want 00", {f_rf_we, f_ram_en}); end
    n_vec++; if (br_bus !== 33'h0) begin n_err++; $display("FAIL nop_br: got %h want 0", br_bus); end
    tick();
    accept(32'h0000_0184);
    inst_sram_rdata = enc_i(6'h23, 5'd1, 5'd8, 16'd4);
    #2;
    n_vec++; if ({f_ram_en, f_sel, f_rf_we, f_ram_wen} !== 7'b1110000) begin n_err++; $display("FAIL lw_ctrl: got %b want 1110000", {f_ram_en, f_sel, f_rf_we, f_ram_wen}); end
    n_vec++; if (f_waddr !== 5'd8) begin n_err++; $display("FAIL lw_waddr: got %0d want 8", f_waddr); end
    tick();
    accept(32'h0000_0188);
    inst_sram_rdata = enc_i(6'h2b, 5'd1, 5'd8, 16'd4);
    #2;
    n_vec++; if ({f_ram_en, f_rf_we, f_ram_wen} !== 6'b101111) begin n_err++; $display("FAIL sw_ctrl: got %b want 101111", {f_ram_en, f_rf_we, f_ram_wen}); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    accept(32'h0000_0200);
    inst_sram_rdata = enc_i(6'h09, 5'd0, 5'd6, 16'd1);
    in_valid = 1'b1;
    in_pc    = 32'h0000_0204;
    #2;
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready: got %0b want 1", in_ready); end
    n_vec++; if (f_pc !== 32'h200) begin n_err++; $display("FAIL b2b_pc0: got %h want 200", f_pc); end
    tick();
    inst_sram_rdata = enc_i(6'h09, 5'd0, 5'd7, 16'd2);
    in_pc = 32'h0000_0208;
    #2;
    n_vec++; if ({out_valid, f_pc} !== {1'b1, 32'h204}) begin n_err++; $display("FAIL b2b_pc1: got %h want 1_00000204", {out_valid, f_pc}); end
    n_vec++; if (f_inst !== 32'h2407_0002) begin n_err++; $display("FAIL b2b_inst1: got %h want 24070002", f_inst); end
    tick();
    in_valid = 1'b0;
    inst_sram_rdata = enc_i(6'h0f, 5'd0, 5'd9, 16'h1234);
    #2;
    n_vec++; if ({out_valid, f_pc} !== {1'b1, 32'h208}) begin n_err++; $display("FAIL b2b_pc2: got %h want 1_00000208", {out_valid, f_pc}); end
    n_vec++; if (f_alu_op !== 12'h800) begin n_err++; $display("FAIL lui_alu_op: got %h want 800", f_alu_op); end
    tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %0b want 0", out_valid); end
    idle();
  endtask

  task automatic test_flush();
    accept(32'h0000_0280);
    inst_sram_rdata = enc_r(5'd4, 5'd0, 5'd5, 6'h21);
    fwd_bus = {78'h0, mk_fwd(1'b1, 1'b1, 5'd4, 32'h0)};
    #2;
    n_vec++; if (stallreq !== 1'b1) begin n_err++; $display("FAIL fl_pre_stall: got %0b want 1", stallreq); end
    flush = 1'b1;
    #1;
    n_vec++; if ({stallreq, out_valid} !== 2'b00) begin n_err++; $display("FAIL fl_force: got %b want 00", {stallreq, out_valid}); end
    n_vec++; if (id_to_ex_bus !== 159'h0) begin n_err++; $display("FAIL fl_bus_zero: got %h want 0", id_to_ex_bus); end
    tick();
    flush   = 1'b0;
    fwd_bus = '0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL fl_empty: got %0b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL fl_in_ready: got %0b want 1", in_ready); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    accept(32'h0000_0300);
    inst_sram_rdata = enc_r(5'd4, 5'd0, 5'd5, 6'h21);
    fwd_bus = {78'h0, mk_fwd(1'b1, 1'b1, 5'd4, 32'h0)};
    #2;
    resetn = 1'b0;
    #1;
    n_vec++; if ({out_valid, stallreq, in_ready} !== 3'b001) begin n_err++; $display("FAIL rms_async: got %b want 001", {out_valid, stallreq, in_ready}); end
    tick();
    resetn = 1'b1;
    fwd_bus = '0;
    #2;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rms_empty: got %0b want 0", out_valid); end
    tick();
    idle();
  endtask

`ifdef ID_PERF_CNT_EN
  task automatic test_perf();
    n_vec++; if (stall_cnt !== 32'd0) begin n_err++; $display("FAIL cnt_rst: got %0d want 0", stall_cnt); end
    accept(32'h0000_0400);
    inst_sram_rdata = enc_r(5'd4, 5'd0, 5'd5, 6'h21);
    fwd_bus = {78'h0, mk_fwd(1'b1, 1'b1, 5'd4, 32'h0)};
    tick();
    tick();
    tick();
    fwd_bus = '0;
    #2;
    n_vec++; if (stall_cnt !== 32'd3) begin n_err++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
    n_vec++; if (br_cnt !== 32'd0) begin n_err++; $display("FAIL br_cnt: got %0d want 0", br_cnt); end
    tick();
    idle();
  endtask
`endif

  initial begin
    test_reset();
    test_addiu();
    test_fwd();
    test_load_use();
    test_branch();
    test_jal();
    test_decode_misc();
    test_back_to_back();
    test_flush();
    test_reset_mid_stall();
`ifdef ID_PERF_CNT_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
